// File: rtl/popcount_acc.sv
// -----------------------------------------------------------------------------
// popcount_acc
//
// Ternary-weight popcount accumulator. Each accepted beat contributes
// popcount(pos_a) - popcount(neg_a), optionally coarsened by clearing the low
// APPROX_LSB bits of each count. After BEATS accepted beats the signed sum is
// presented on out_sum together with a ternary activation on out_act, and is
// held until the consumer takes it.
//
// Ports
//   clk        : single clock, rising-edge
//   rst        : synchronous active-high reset
//   in_valid   : beat offered
//   in_ready   : beat accepted when in_valid && in_ready
//   pos_a      : N positive-weight activation bits
//   neg_a      : N negative-weight activation bits
//   out_valid  : result available
//   out_ready  : result consumed when out_valid && out_ready
//   out_sum    : signed accumulated difference (ACCW bits)
//   out_act    : 2'b01 = +1, 2'b00 = 0, 2'b11 = -1
// -----------------------------------------------------------------------------
module popcount_acc #(
    parameter int N          = 9,
    parameter int BEATS      = 4,
    parameter int THR        = 2,
    parameter int APPROX_LSB = 0,
    localparam int CW        = $clog2(N + 1),
    localparam int ACCW      = $clog2(BEATS * N + 1) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           pos_a,
    input  logic [N-1:0]           neg_a,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [ACCW-1:0] out_sum,
    output logic [1:0]             out_act
);

    // Counter needs at least one bit even when a result is a single beat.
    localparam int CNTW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);
    // Keeps the high bits of a count; the cleared low bits implement the
    // approximate mode.
    localparam logic [CW-1:0] TRUNC_MASK = CW'(32'hFFFF_FFFF << APPROX_LSB);
    localparam logic signed [31:0] THR_S = 32'(THR);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Number of set bits in one input word.
    function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Ternary activation; values exactly at +/-THR map to zero.
    function automatic logic [1:0] ternary(input logic signed [ACCW-1:0] s);
        logic signed [31:0] s_ext;
        logic [1:0]         a;
        s_ext = 32'(s);
        if (s_ext > THR_S) begin
            a = 2'b01;
        end else if (s_ext < -THR_S) begin
            a = 2'b11;
        end else begin
            a = 2'b00;
        end
        return a;
    endfunction

    state_t                 state_r;
    logic [CNTW-1:0]        cnt_r;
    logic signed [ACCW-1:0] acc_r;
    logic signed [ACCW-1:0] out_sum_r;
    logic [1:0]             out_act_r;
    logic                   out_valid_r;

    logic [CW-1:0]          pc_pos_s;
    logic [CW-1:0]          pc_neg_s;
    logic signed [ACCW-1:0] beat_d_s;
    logic signed [ACCW-1:0] acc_nxt_s;
    logic                   accept_s;

    // Ready only while accumulating and never while reset is asserted, so the
    // first cycle after reset release can already accept a beat.
    assign in_ready = (state_r == ST_ACC) && !rst;
    assign accept_s = in_valid && in_ready;

    // Per-beat difference and the accumulator value it would produce. Counts
    // are zero-extended into ACCW bits, which always has a spare sign bit, so
    // the subtraction and the running sum can never overflow.
    always_comb begin
        pc_pos_s  = popcnt(pos_a) & TRUNC_MASK;
        pc_neg_s  = popcnt(neg_a) & TRUNC_MASK;
        beat_d_s  = $signed(ACCW'(pc_pos_s)) - $signed(ACCW'(pc_neg_s));
        acc_nxt_s = acc_r + beat_d_s;
    end

    // Control state, beat counter, accumulator and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ACC;
            cnt_r       <= {CNTW{1'b0}};
            acc_r       <= {ACCW{1'b0}};
            out_sum_r   <= {ACCW{1'b0}};
            out_act_r   <= 2'b00;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ACC: begin
                    if (accept_s) begin
                        if (cnt_r == LAST_BEAT) begin
                            // Final beat: publish the completed sum directly.
                            state_r     <= ST_DONE;
                            cnt_r       <= {CNTW{1'b0}};
                            acc_r       <= acc_nxt_s;
                            out_sum_r   <= acc_nxt_s;
                            out_act_r   <= ternary(acc_nxt_s);
                            out_valid_r <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNTW'(1);
                            acc_r <= acc_nxt_s;
                        end
                    end else begin
                        cnt_r <= cnt_r;
                        acc_r <= acc_r;
                    end
                end
                ST_DONE: begin
                    // Input side is ignored here; only the consumer moves us on.
                    if (out_ready) begin
                        state_r     <= ST_ACC;
                        cnt_r       <= {CNTW{1'b0}};
                        acc_r       <= {ACCW{1'b0}};
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_ACC;
                    cnt_r       <= {CNTW{1'b0}};
                    acc_r       <= {ACCW{1'b0}};
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_act   = out_act_r;

endmodule

// File: tb/tb_popcount_acc.sv
// -----------------------------------------------------------------------------
// tb_popcount_acc
//
// Self-checking bench for popcount_acc. Two instances share every input: one
// exact (APPROX_LSB=0) and one approximate (APPROX_LSB=1). Expected results
// come from a behavioural model using $countones and plain integer sums.
// -----------------------------------------------------------------------------
module tb_popcount_acc;

    localparam int N     = 9;
    localparam int BEATS = 4;
    localparam int THR   = 2;
    localparam int ACCW  = $clog2(BEATS * N + 1) + 1;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic [N-1:0]           pos_a;
    logic [N-1:0]           neg_a;
    logic                   out_ready;
    logic                   in_ready,  in_ready_ap;
    logic                   out_valid, out_valid_ap;
    logic signed [ACCW-1:0] out_sum,   out_sum_ap;
    logic [1:0]             out_act,   out_act_ap;

    int n_checks = 0;
    int n_fail   = 0;

    popcount_acc #(.N(N), .BEATS(BEATS), .THR(THR), .APPROX_LSB(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pos_a(pos_a), .neg_a(neg_a), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_act(out_act)
    );

    popcount_acc #(.N(N), .BEATS(BEATS), .THR(THR), .APPROX_LSB(1)) dut_ap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ap),
        .pos_a(pos_a), .neg_a(neg_a), .out_valid(out_valid_ap),
        .out_ready(out_ready), .out_sum(out_sum_ap), .out_act(out_act_ap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int beat_val(input logic [N-1:0] p, input logic [N-1:0] n, input int lsb);
        int cp, cn;
        cp = ($countones(p) >> lsb) << lsb;
        cn = ($countones(n) >> lsb) << lsb;
        return cp - cn;
    endfunction

    function automatic logic [1:0] act_of(input int s);
        if (s > THR) return 2'b01;
        else if (s < -THR) return 2'b11;
        else return 2'b00;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and return 1 ns after the edge that accepted it.
    task automatic send_beat(input logic [N-1:0] p, input logic [N-1:0] n);
        int waited;
        pos_a    = p;
        neg_a    = n;
        in_valid = 1'b1;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL send_beat_timeout: in_ready=%b, required 1", in_ready);
        end else begin
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; pos_a = 9'h1FF; neg_a = 9'h000;
        step(); step();
        n_checks++; if (in_ready !== 1'b0 || in_ready_ap !== 1'b0) begin n_fail++;
            $display("FAIL reset_in_ready: got %b/%b, required 0", in_ready, in_ready_ap); end
        n_checks++; if (out_valid !== 1'b0 || out_valid_ap !== 1'b0) begin n_fail++;
            $display("FAIL reset_out_valid: got %b/%b, required 0", out_valid, out_valid_ap); end
        n_checks++; if (int'(out_sum) !== 0 || out_act !== 2'b00) begin n_fail++;
            $display("FAIL reset_outputs: sum=%0d act=%b, required 0/00", out_sum, out_act); end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_all_pos();
        for (int i = 0; i < BEATS; i++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++;
                $display("FAIL pos_early_valid beat %0d: got %b, required 0", i, out_valid); end
            send_beat(9'h1FF, 9'h000);
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++;
            $display("FAIL pos_latency: out_valid=%b, required 1", out_valid); end
        n_checks++; if (int'(out_sum) !== 36 || out_act !== 2'b01) begin n_fail++;
            $display("FAIL pos_result: sum=%0d act=%b, required 36/01", out_sum, out_act); end
        consume();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++;
            $display("FAIL pos_consume: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid); end
    endtask

    task automatic test_all_neg();
        for (int i = 0; i < BEATS; i++) send_beat(9'h000, 9'h1FF);
        n_checks++; if (out_valid !== 1'b1 || int'(out_sum) !== -36 || out_act !== 2'b11) begin n_fail++;
            $display("FAIL neg_result: valid=%b sum=%0d act=%b, required 1/-36/11", out_valid, out_sum, out_act); end
        n_checks++; if (int'(out_sum_ap) !== -32 || out_act_ap !== 2'b11) begin n_fail++;
            $display("FAIL neg_result_ap: sum=%0d act=%b, required -32/11", out_sum_ap, out_act_ap); end
        consume();
    endtask

    task automatic test_threshold();
        send_beat(9'h003, 9'h001); send_beat(9'h003, 9'h001);
        send_beat(9'h001, 9'h001); send_beat(9'h001, 9'h001);
        n_checks++; if (int'(out_sum) !== 2 || out_act !== 2'b00) begin n_fail++;
            $display("FAIL thr_plus_edge: sum=%0d act=%b, required 2/00", out_sum, out_act); end
        consume();
        for (int i = 0; i < BEATS; i++) send_beat(9'h003, 9'h001);
        n_checks++; if (int'(out_sum) !== 4 || out_act !== 2'b01) begin n_fail++;
            $display("FAIL thr_above: sum=%0d act=%b, required 4/01", out_sum, out_act); end
        consume();
        send_beat(9'h001, 9'h003); send_beat(9'h001, 9'h003);
        send_beat(9'h000, 9'h000); send_beat(9'h000, 9'h000);
        n_checks++; if (int'(out_sum) !== -2 || out_act !== 2'b00) begin n_fail++;
            $display("FAIL thr_minus_edge: sum=%0d act=%b, required -2/00", out_sum, out_act); end
        consume();
        send_beat(9'h001, 9'h007); send_beat(9'h000, 9'h000);
        send_beat(9'h000, 9'h000); send_beat(9'h000, 9'h000);
        n_checks++; if (int'(out_sum) !== -2 || out_act !== 2'b00) begin n_fail++;
            $display("FAIL thr_minus_edge2: sum=%0d act=%b, required -2/00", out_sum, out_act); end
        consume();
        send_beat(9'h000, 9'h007); send_beat(9'h000, 9'h000);
        send_beat(9'h000, 9'h000); send_beat(9'h000, 9'h000);
        n_checks++; if (int'(out_sum) !== -3 || out_act !== 2'b11) begin n_fail++;
            $display("FAIL thr_below: sum=%0d act=%b, required -3/11", out_sum, out_act); end
        consume();
    endtask

    task automatic test_backpressure();
        int exp_s;
        exp_s = 0;
        for (int i = 0; i < BEATS; i++) begin
            logic [N-1:0] p, n;
            p = N'($urandom); n = N'($urandom);
            exp_s += beat_val(p, n, 0);
            send_beat(p, n);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            pos_a = 9'h1FF; neg_a = N'($urandom);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(out_sum) !== exp_s || out_act !== act_of(exp_s)) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b sum=%0d act=%b, required 1/0/%0d/%b",
                         i, out_valid, in_ready, out_sum, out_act, exp_s, act_of(exp_s));
            end
        end
        in_valid = 1'b0;
        consume();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL bp_release_ready: got %b, required 1", in_ready); end
        for (int i = 0; i < BEATS; i++) send_beat(9'h001, 9'h000);
        n_checks++; if (int'(out_sum) !== 4) begin n_fail++;
            $display("FAIL bp_fresh_sum: got %0d, required 4", out_sum); end
        consume();
    endtask

    task automatic test_reset_mid();
        send_beat(9'h1FF, 9'h000); send_beat(9'h1FF, 9'h000);
        rst = 1'b1;
        step();
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || int'(out_sum) !== 0) begin n_fail++;
            $display("FAIL mid_reset_state: ready=%b valid=%b sum=%0d, required 0/0/0", in_ready, out_valid, out_sum); end
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL mid_reset_ready: got %b, required 1", in_ready); end
        for (int i = 0; i < BEATS; i++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_fail++;
                $display("FAIL mid_early_valid beat %0d: got %b, required 0", i, out_valid); end
            send_beat(9'h001, 9'h000);
        end
        n_checks++; if (out_valid !== 1'b1 || int'(out_sum) !== 4) begin n_fail++;
            $display("FAIL mid_result: valid=%b sum=%0d, required 1/4", out_valid, out_sum); end
        // Reset while a result is pending must drop it.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++;
                $display("FAIL done_reset_drop cycle %0d: out_valid=%b, required 0", i, out_valid); end
        end
    endtask

    task automatic test_approx();
        for (int i = 0; i < BEATS; i++) send_beat(9'h007, 9'h000);
        n_checks++; if (out_valid_ap !== 1'b1 || int'(out_sum_ap) !== 8 || out_act_ap !== 2'b01) begin n_fail++;
            $display("FAIL approx_result: valid=%b sum=%0d act=%b, required 1/8/01", out_valid_ap, out_sum_ap, out_act_ap); end
        n_checks++; if (int'(out_sum) !== 12) begin n_fail++;
            $display("FAIL approx_exact_ref: sum=%0d, required 12", out_sum); end
        consume();
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            int exp_s, exp_a;
            exp_s = 0; exp_a = 0;
            for (int i = 0; i < BEATS; i++) begin
                logic [N-1:0] p, n, m;
                m = ($urandom_range(0, 1) == 0) ? 9'h1FF : 9'h007;
                p = N'($urandom) & m; n = N'($urandom) & m;
                exp_s += beat_val(p, n, 0);
                exp_a += beat_val(p, n, 1);
                send_beat(p, n);
                if (i < BEATS - 1) begin
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                        pos_a = N'($urandom); neg_a = N'($urandom);
                        step();
                    end
                end
            end
            n_checks++;
            if (out_valid !== 1'b1 || int'(out_sum) !== exp_s || out_act !== act_of(exp_s)) begin
                n_fail++;
                $display("FAIL rand_exact %0d: valid=%b sum=%0d act=%b, required 1/%0d/%b",
                         r, out_valid, out_sum, out_act, exp_s, act_of(exp_s));
            end
            n_checks++;
            if (int'(out_sum_ap) !== exp_a || out_act_ap !== act_of(exp_a)) begin
                n_fail++;
                $display("FAIL rand_approx %0d: sum=%0d act=%b, required %0d/%b",
                         r, out_sum_ap, out_act_ap, exp_a, act_of(exp_a));
            end
            for (int h = 0; h < int'($urandom_range(0, 3)); h++) step();
            consume();
        end
    endtask

    task automatic test_back_to_back();
        int last, seen;
        last = -1; seen = 0;
        pos_a = 9'h0FF; neg_a = 9'h003;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            step();
            if (out_valid === 1'b1) begin
                seen++;
                n_checks++; if (int'(out_sum) !== 24 || out_act !== 2'b01) begin n_fail++;
                    $display("FAIL b2b_sum cycle %0d: sum=%0d act=%b, required 24/01", c, out_sum, out_act); end
                if (last >= 0) begin
                    n_checks++; if (c - last !== BEATS + 1) begin n_fail++;
                        $display("FAIL b2b_spacing: got %0d cycles, required %0d", c - last, BEATS + 1); end
                end
                last = c;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        n_checks++; if (seen !== 3) begin n_fail++;
            $display("FAIL b2b_count: got %0d results, required 3", seen); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        pos_a = 9'h000; neg_a = 9'h000;
        test_reset();
        test_all_pos();
        test_all_neg();
        test_threshold();
        test_backpressure();
        test_reset_mid();
        test_approx();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/popcount_acc.md
POPCOUNT_ACC -- requirements
Module: popcount_acc

Interface
REQ-001 SHALL have parameter N, default 9: width of each input word (bits counted per beat).
REQ-002 SHALL have parameter BEATS, default 4: beats accumulated per result, >=1.
REQ-003 SHALL have parameter THR, default 2: non-negative ternary activation threshold.
REQ-004 SHALL have parameter APPROX_LSB, default 0: low bits cleared in each per-beat popcount; 0 gives exact counting.
REQ-005 SHALL define CW = clog2(N+1) and ACCW = clog2(BEATS*N+1)+1.
REQ-006 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1: beat offered.
REQ-009 SHALL have port in_ready, output, 1: beat accepted when in_valid and in_ready are both high.
REQ-010 SHALL have port pos_a, input, N: positive-weight activation bits.
REQ-011 SHALL have port neg_a, input, N: negative-weight activation bits.
REQ-012 SHALL have port out_valid, output, 1: result available.
REQ-013 SHALL have port out_ready, input, 1: result consumed when out_valid and out_ready are both high.
REQ-014 SHALL have port out_sum, output, ACCW, signed: accumulated difference.
REQ-015 SHALL have port out_act, output, 2, two's complement: 2'b01 = +1, 2'b00 = 0, 2'b11 = -1.

Function
REQ-016 SHALL compute per accepted beat d = trunc(popcount(pos_a)) - trunc(popcount(neg_a)), where trunc clears the low APPROX_LSB bits of the CW-bit count.
REQ-017 SHALL sign-extend d to ACCW bits and add it to the accumulator, with no overflow possible at any parameter set.
REQ-018 SHALL implement two states: ACC and DONE.
REQ-019 SHALL drive in_ready high only in ACC and only while rst is low; out_valid SHALL be high only in DONE.
REQ-020 SHALL count accepted beats in ACC with a counter from 0 to BEATS-1.
REQ-021 SHALL, on the beat that brings the counter to BEATS-1, add the final d, enter DONE on the next edge, and raise out_valid exactly 1 cycle after that final acceptance.
REQ-022 SHALL hold out_sum and out_act stable while in DONE.
REQ-023 SHALL ignore in_valid and input data while in DONE.
REQ-024 SHALL, when out_valid and out_ready are both high, clear the accumulator and beat counter and return to ACC, so in_ready is high the following cycle.
REQ-025 SHALL drive out_act = +1 when out_sum > THR, -1 when out_sum < -THR, and 0 otherwise; both boundaries (|out_sum| = THR) SHALL give 0.
REQ-026 SHALL, when BEATS = 1, produce a result after each single accepted beat with the same 1-cycle latency.
REQ-027 SHALL sustain a throughput of one result per BEATS+1 cycles when out_ready is held high.
REQ-028 SHALL hold accumulator and counter unchanged in ACC when in_valid is low, so gaps between beats are allowed.

Reset
REQ-029 SHALL, while rst is high, force state to ACC, accumulator and counter to 0, out_valid to 0, in_ready to 0, out_sum to 0 and out_act to 2'b00.
REQ-030 SHALL, on reset mid-accumulation or during DONE, discard the partial or pending result, with no result emitted for it.
REQ-031 SHALL give in_ready = 1 in the first cycle after rst falls.

Verification (N=9, BEATS=4, THR=2, APPROX_LSB=0 unless stated)
REQ-032 SHALL cover: 4 beats of pos_a=9'h1FF, neg_a=0 -> out_sum=36, out_act=2'b01, out_valid high 1 cycle after the 4th acceptance.
REQ-033 SHALL cover: 4 beats of pos_a=0, neg_a=9'h1FF -> out_sum=-36, out_act=2'b11.
REQ-034 SHALL cover the threshold boundary: beats (pos_a, neg_a) = (9'h003, 9'h001) x2 then (9'h001, 9'h001) x2 -> out_sum=2, out_act=2'b00; a repeat with all four beats (9'h003, 9'h001) -> out_sum=4, out_act=2'b01.
REQ-035 SHALL cover backpressure: out_ready low for 5 cycles with in_valid toggling -> out_sum and out_act stable, in_ready=0, no beat counted; then one out_ready pulse -> in_ready=1 next cycle.
REQ-036 SHALL cover reset mid-operation: rst pulsed after 2 beats of pos_a=9'h1FF, then 4 beats of pos_a=9'h001, neg_a=0 -> out_sum=4, with no earlier out_valid.
REQ-037 SHALL cover approximation with APPROX_LSB=1: 4 beats of pos_a=9'h007, neg_a=0 -> each beat count 3 truncated to 2, out_sum=8, out_act=2'b01.
